usb_rx_bit_timer: RTL

//  Bit-timing and bit-unstuffing stage of the USB full-speed receive path. Runs at

---
 rtl/usb_rx_bit_timer_pkg.sv | 15 +
 rtl/usb_rx_bit_timer_if.sv | 24 ++
 rtl/usb_rx_bit_timer_flex_counter.sv | 46 ++++
 rtl/usb_rx_bit_timer.sv | 108 ++++++++++
 4 files changed

// File: rtl/usb_rx_bit_timer_pkg.sv
// Shared constants for the USB full-speed receive bit timer.
// Also holds the helper that sizes a counter from its range.
package usb_rx_pkg;

  localparam int USB_CLKS_PER_BIT  = 8;
  localparam int USB_SAMPLE_PHASE  = 3;
  localparam int USB_BITS_PER_BYTE = 8;
  localparam int USB_STUFF_LIMIT   = 6;

  // Counter width for values 0..range-1, never narrower than one bit
  function automatic int cnt_width(input int range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer_if.sv
// Receive-path signals between the bit timer and its neighbours.
// Master is the surrounding RX logic; slave is the bit timer.
interface usb_rx_bit_timer_if;

  logic rcving;
  logic d_edge;
  logic eop;
  logic d_orig;
  logic shift_enable;
  logic bit_strobe;
  logic byte_received;
  logic stuff_err;

  modport master (
    output rcving, d_edge, eop, d_orig,
    input  shift_enable, bit_strobe, byte_received, stuff_err
  );

  modport slave (
    input  rcving, d_edge, eop, d_orig,
    output shift_enable, bit_strobe, byte_received, stuff_err
  );

endinterface

// File: rtl/usb_rx_bit_timer_flex_counter.sv
// Parameterised rollover counter: counts 0..rollover_val and wraps to 0.
// A synchronous clear has priority over counting.
module usb_flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic [NUM_BITS-1:0] count_r;
  logic [NUM_BITS-1:0] count_nxt_s;

  // next count: clear, wrap at rollover_val, or increment
  always_comb begin
    count_nxt_s = count_r;
    if (clear) begin
      count_nxt_s = '0;
    end else if (count_enable) begin
      if (count_r == rollover_val) begin
        count_nxt_s = '0;
      end else begin
        count_nxt_s = count_r + {{(NUM_BITS-1){1'b0}}, 1'b1};
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // count register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count_out     = count_r;
  assign rollover_flag = (count_r == rollover_val);

endmodule

// File: rtl/usb_rx_bit_timer.sv
// Bit timing and unstuffing for the USB full-speed receive path: mid-bit shift
// strobes locked to D+ edges, stuff-bit removal and byte framing.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE  = USB_SAMPLE_PHASE,
  parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
  parameter int STUFF_LIMIT   = USB_STUFF_LIMIT
) (
  input logic               clk,
  input logic               n_rst,
  usb_rx_bit_timer_if.slave bus
);

  localparam int PH_W = cnt_width(CLKS_PER_BIT);
  localparam int BC_W = cnt_width(BITS_PER_BYTE);
  localparam int ON_W = cnt_width(STUFF_LIMIT + 1);

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BITS_PER_BYTE - 1);
  localparam logic [ON_W-1:0] ON_LIMIT  = ON_W'(STUFF_LIMIT);
  localparam logic [ON_W-1:0] ON_ONE    = ON_W'(1);

  logic [PH_W-1:0] ph_s;
  logic            ph_clear_s;
  logic            sample_s;
  logic            stuffed_s;
  logic            bit_strobe_s;
  logic            bit_clear_s;
  logic            bit_last_s;
  logic [ON_W-1:0] ones_r;
  logic [ON_W-1:0] ones_nxt_s;
  logic            byte_received_r;
  logic            stuff_err_r;

  // An edge restarts the bit period so the sample stays centred on the data eye
  assign ph_clear_s = ~bus.rcving | bus.d_edge;

  usb_flex_counter #(
    .NUM_BITS (PH_W)
  ) u_phase_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (ph_clear_s),
    .count_enable  (1'b1),
    .rollover_val  (PH_LAST),
    .count_out     (ph_s),
    .rollover_flag ()
  );

  assign sample_s     = bus.rcving & (ph_s == PH_SAMPLE);
  assign stuffed_s    = sample_s & (ones_r == ON_LIMIT);
  assign bit_strobe_s = sample_s & ~stuffed_s & ~bus.eop;

  // EOP at a sample drops any partial byte
  assign bit_clear_s = ~bus.rcving | (sample_s & bus.eop);

  usb_flex_counter #(
    .NUM_BITS (BC_W)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (bit_clear_s),
    .count_enable  (bit_strobe_s),
    .rollover_val  (BC_LAST),
    .count_out     (),
    .rollover_flag (bit_last_s)
  );

  // run length of decoded ones, restarted by a zero, a stuff bit or EOP
  always_comb begin
    ones_nxt_s = ones_r;
    if (!bus.rcving) begin
      ones_nxt_s = '0;
    end else if (sample_s) begin
      if (bus.eop || stuffed_s) begin
        ones_nxt_s = '0;
      end else if (bus.d_orig) begin
        ones_nxt_s = ones_r + ON_ONE;
      end else begin
        ones_nxt_s = '0;
      end
    end else begin
      ones_nxt_s = ones_r;
    end
  end

  // ones counter and registered pulse outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_r          <= '0;
      byte_received_r <= 1'b0;
      stuff_err_r     <= 1'b0;
    end else begin
      ones_r          <= ones_nxt_s;
      byte_received_r <= bit_strobe_s & bit_last_s;
      stuff_err_r     <= stuffed_s & bus.d_orig;
    end
  end

  assign bus.shift_enable  = sample_s;
  assign bus.bit_strobe    = bit_strobe_s;
  assign bus.byte_received = byte_received_r;
  assign bus.stuff_err     = stuff_err_r;

endmodule
